// File: rtl/dvi_tx_pkg.sv
// Shared TMDS definitions for the DVI transmit path.
//   TMDS_WORD_W      : width of one TMDS symbol.
//   CTRL_00..CTRL_11 : TMDS control tokens, indexed by {C1,C0}, in data[] bit numbering.
//   bit_reverse()    : mirrors a TMDS symbol end for end (data[0] <-> data[9]).
package dvi_tx_pkg;

  localparam int TMDS_WORD_W = 10;

  localparam logic [TMDS_WORD_W-1:0] CTRL_00 = 10'b1101010100;
  localparam logic [TMDS_WORD_W-1:0] CTRL_01 = 10'b0010101011;
  localparam logic [TMDS_WORD_W-1:0] CTRL_10 = 10'b0101010100;
  localparam logic [TMDS_WORD_W-1:0] CTRL_11 = 10'b1010101011;

  function automatic logic [TMDS_WORD_W-1:0] bit_reverse(input logic [TMDS_WORD_W-1:0] word);
    logic [TMDS_WORD_W-1:0] r;
    for (int i = 0; i < TMDS_WORD_W; i++) begin
      r[i] = word[TMDS_WORD_W-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/dvi_tx_lane_shifter.sv
// One lane of the TMDS gearbox: loads a symbol and shifts it out OUT_W bits per clock.
//   clk, rst : serial clock, asynchronous active-high reset
//   load     : capture word (bit-reversed first when MSB_FIRST=1)
//   shift    : shift right by OUT_W with zero fill (ignored while load is high)
//   word     : symbol to load, data[] bit numbering
//   slice    : current low OUT_W bits of the shift register; bit 0 goes out first
module dvi_tx_lane_shifter #(
  parameter int WORD_W    = 10,
  parameter int OUT_W     = 2,
  parameter int MSB_FIRST = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic [WORD_W-1:0] word,
  output logic [OUT_W-1:0]  slice
);

  logic [WORD_W-1:0] shift_reg;
  logic [WORD_W-1:0] load_word;

  // Reversing at load time lets the register always drain from bit 0,
  // so both bit orders share the same shifter and slice tap.
  always_comb begin
    load_word = word;
    if (MSB_FIRST != 0) begin
      for (int i = 0; i < WORD_W; i++) begin
        load_word[i] = word[WORD_W-1-i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg <= '0;
    end else if (load) begin
      shift_reg <= load_word;
    end else if (shift) begin
      shift_reg <= shift_reg >> OUT_W;
    end
  end

  assign slice = shift_reg[OUT_W-1:0];

endmodule

// File: rtl/dvi_tx_tmds_gearbox.sv
// Multi-lane TMDS word-to-slice gearbox in the serial clock domain.
//   ddr_bit_clock   : serial clock, one OUT_W slice per lane per cycle
//   reset           : asynchronous active-high reset
//   enable          : advance phase counter and shifters; low freezes them
//   in_valid/in_ready/in_data : symbol-set input, lane l at [l*WORD_W +: WORD_W]
//   out_bits        : lane l slice at [l*OUT_W +: OUT_W], bit 0 earliest
//   word_start      : out_bits carries the first slice of a freshly loaded word
//   underflow       : sticky, a load found the holding register empty
//   clear_underflow : synchronous clear of underflow (a simultaneous set wins)
module dvi_tx_tmds_gearbox
  import dvi_tx_pkg::*;
#(
  parameter int               LANES     = 3,
  parameter int               WORD_W    = TMDS_WORD_W,
  parameter int               OUT_W     = 2,
  parameter int               MSB_FIRST = 0,
  parameter logic [WORD_W-1:0] IDLE_WORD = WORD_W'(CTRL_00)
) (
  input  logic                    ddr_bit_clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*WORD_W-1:0] in_data,
  output logic [LANES*OUT_W-1:0]  out_bits,
  output logic                    word_start,
  output logic                    underflow,
  input  logic                    clear_underflow
);

  localparam int PHASES = WORD_W / OUT_W;
  localparam int PH_W   = (PHASES > 1) ? $clog2(PHASES) : 1;
  localparam logic [PH_W-1:0] LAST_PHASE = PH_W'(PHASES - 1);

  if ((WORD_W % OUT_W) != 0 || OUT_W > WORD_W) begin : g_bad_cfg
    $error("dvi_tx_tmds_gearbox: OUT_W must divide WORD_W and not exceed it");
  end

  logic [PH_W-1:0]         phase;
  logic                    hold_full;
  logic [LANES*WORD_W-1:0] hold;
  logic                    load_event;
  logic                    accept;

  assign load_event = enable && (phase == LAST_PHASE);

  // Handshake: a transfer happens on every edge where in_valid && in_ready.
  // in_valid may be held across cycles; in_ready depends on the holding
  // register and the load event only, never on in_valid. The slot frees up
  // on the load edge itself, so a new set can be taken in that same cycle.
  assign in_ready = !hold_full || load_event;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge ddr_bit_clock or posedge reset) begin
    if (reset) begin
      phase      <= '0;
      hold_full  <= 1'b0;
      hold       <= '0;
      word_start <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      if (enable) begin
        phase <= (phase == LAST_PHASE) ? '0 : phase + 1'b1;
      end
      if (accept) begin
        hold      <= in_data;
        hold_full <= 1'b1;
      end else if (load_event) begin
        hold_full <= 1'b0;
      end
      word_start <= load_event;
      if (load_event && !hold_full) begin
        underflow <= 1'b1;
      end else if (clear_underflow) begin
        underflow <= 1'b0;
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [WORD_W-1:0] lane_word;
    assign lane_word = hold_full ? hold[l*WORD_W +: WORD_W] : IDLE_WORD;

    dvi_tx_lane_shifter #(
      .WORD_W    (WORD_W),
      .OUT_W     (OUT_W),
      .MSB_FIRST (MSB_FIRST)
    ) u_shifter (
      .clk   (ddr_bit_clock),
      .rst   (reset),
      .load  (load_event),
      .shift (enable && !load_event),
      .word  (lane_word),
      .slice (out_bits[l*OUT_W +: OUT_W])
    );
  end

endmodule

// File: tb/tb_dvi_tx_tmds_gearbox.sv
module tb_dvi_tx_tmds_gearbox;

  localparam int LANES  = 3;
  localparam int WORD_W = 10;
  localparam int OUT_W  = 2;
  localparam int PHASES = WORD_W / OUT_W;
  localparam int DW     = LANES * WORD_W;
  localparam int OW     = LANES * OUT_W;
  localparam logic [WORD_W-1:0] IDLE = 10'b1101010100;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          enable = 1'b0;
  logic          in_valid = 1'b0;
  logic          clear_underflow = 1'b0;
  logic [DW-1:0] in_data = '0;

  logic          in_ready_a, in_ready_b;
  logic [OW-1:0] out_a, out_b;
  logic          ws_a, ws_b, uf_a, uf_b;

  dvi_tx_tmds_gearbox #(.LANES(LANES), .WORD_W(WORD_W), .OUT_W(OUT_W), .MSB_FIRST(0)) dut_lsb (
    .ddr_bit_clock(clk), .reset(reset), .enable(enable), .in_valid(in_valid),
    .in_ready(in_ready_a), .in_data(in_data), .out_bits(out_a), .word_start(ws_a),
    .underflow(uf_a), .clear_underflow(clear_underflow));

  dvi_tx_tmds_gearbox #(.LANES(LANES), .WORD_W(WORD_W), .OUT_W(OUT_W), .MSB_FIRST(1)) dut_msb (
    .ddr_bit_clock(clk), .reset(reset), .enable(enable), .in_valid(in_valid),
    .in_ready(in_ready_b), .in_data(in_data), .out_bits(out_b), .word_start(ws_b),
    .underflow(uf_b), .clear_underflow(clear_underflow));

  // ---------------- reference model ----------------
  // Words waiting to be transmitted (at most one), the word on the wire,
  // and how many slices of it have already gone out.
  logic [DW-1:0] exp_q[$];
  int            m_phase;
  logic [DW-1:0] m_cur;
  int            m_idx;
  logic          m_ws, m_uf;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int first_ws = 0;
  int rdy_pulses = 0;
  logic [OUT_W-1:0] lane0_log[5];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [WORD_W-1:0] rev10(input logic [WORD_W-1:0] w);
    logic [WORD_W-1:0] r;
    for (int i = 0; i < WORD_W; i++) r[i] = w[WORD_W-1-i];
    return r;
  endfunction

  // Slice m_idx of the current word per lane; zeros once the word is exhausted.
  function automatic logic [OW-1:0] exp_out(input bit msb_first);
    logic [WORD_W-1:0] w;
    logic [OW-1:0] r;
    r = '0;
    for (int l = 0; l < LANES; l++) begin
      w = m_cur[l*WORD_W +: WORD_W];
      if (msb_first) w = rev10(w);
      if (m_idx * OUT_W < WORD_W) begin
        w = w >> (m_idx * OUT_W);
        r[l*OUT_W +: OUT_W] = w[OUT_W-1:0];
      end
    end
    return r;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_phase = 0;
    m_cur = '0;
    m_idx = 0;
    m_ws = 1'b0;
    m_uf = 1'b0;
  endtask

  task automatic model_advance(input logic en, input logic vld, input logic clr,
                               input logic [DW-1:0] data);
    logic load, acc, was_empty;
    load = en && (m_phase == PHASES - 1);
    was_empty = (exp_q.size() == 0);
    acc = vld && (was_empty || load);
    if (load) begin
      if (!was_empty) m_cur = exp_q.pop_front();
      else m_cur = {LANES{IDLE}};
      m_idx = 0;
    end else if (en) begin
      m_idx++;
    end
    if (load && was_empty) m_uf = 1'b1;
    else if (clr) m_uf = 1'b0;
    m_ws = load;
    if (en) m_phase = (m_phase + 1) % PHASES;
    if (acc) exp_q.push_back(data);
  endtask

  task automatic check_outputs();
    check("out_lsb", 32'(out_a), 32'(exp_out(1'b0)));
    check("out_msb", 32'(out_b), 32'(exp_out(1'b1)));
    check("word_start_lsb", 32'(ws_a), 32'(m_ws));
    check("word_start_msb", 32'(ws_b), 32'(m_ws));
    check("underflow_lsb", 32'(uf_a), 32'(m_uf));
    check("underflow_msb", 32'(uf_b), 32'(m_uf));
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic en, input logic vld, input logic clr, input logic [DW-1:0] data);
    logic exp_rdy;
    @(negedge clk);
    cyc++;
    check_outputs();
    if (cyc >= 6 && cyc <= 10) lane0_log[cyc-6] = out_a[OUT_W-1:0];
    if (ws_a && first_ws == 0) first_ws = cyc;
    enable = en;
    in_valid = vld;
    clear_underflow = clr;
    in_data = data;
    #1;
    exp_rdy = (exp_q.size() == 0) || (en && m_phase == PHASES - 1);
    check("in_ready_lsb", 32'(in_ready_a), 32'(exp_rdy));
    check("in_ready_msb", 32'(in_ready_b), 32'(exp_rdy));
    if (in_ready_a) rdy_pulses++;
    model_advance(en, vld, clr, data);
  endtask

  // Asserts reset between clock edges and checks the asynchronous effect at once.
  task automatic do_reset(input bit check_now);
    @(negedge clk);
    #1;
    reset = 1'b1;
    enable = 1'b0;
    in_valid = 1'b0;
    clear_underflow = 1'b0;
    #1;
    if (check_now) begin
      check("rst_out_lsb", 32'(out_a), 32'd0);
      check("rst_out_msb", 32'(out_b), 32'd0);
      check("rst_ready", 32'(in_ready_a), 32'd1);
      check("rst_word_start", 32'(ws_a), 32'd0);
    end
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    cyc = 0;
    first_ws = 0;
  endtask

  function automatic logic [DW-1:0] rand_word();
    return DW'($urandom);
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [DW-1:0] d;
    logic reached;

    // Idle insertion straight out of reset.
    do_reset(1'b0);
    for (int n = 0; n < 12; n++) step(1'b1, 1'b0, 1'b0, '0);
    check("first_word_start_cycle", 32'(first_ws), 32'd6);
    check("idle_slice0", 32'(lane0_log[0]), 32'(2'b00));
    check("idle_slice1", 32'(lane0_log[1]), 32'(2'b01));
    check("idle_slice2", 32'(lane0_log[2]), 32'(2'b01));
    check("idle_slice3", 32'(lane0_log[3]), 32'(2'b01));
    check("idle_slice4", 32'(lane0_log[4]), 32'(2'b11));
    check("underflow_after_idle", 32'(uf_a), 32'd1);

    // Constant patterns with continuous valid, underflow cleared once the hold is full.
    d = {10'h2AA, 10'h000, 10'h3FF};
    step(1'b1, 1'b1, 1'b0, d);
    step(1'b1, 1'b1, 1'b1, d);
    step(1'b1, 1'b1, 1'b1, d);
    for (int n = 0; n < 10; n++) step(1'b1, 1'b1, 1'b0, d);
    rdy_pulses = 0;
    for (int n = 0; n < 20; n++) step(1'b1, 1'b1, 1'b0, d);
    check("ready_pulses_per_20", 32'(rdy_pulses), 32'd4);
    check("steady_out", 32'(out_a), 32'(6'b10_00_11));
    check("underflow_stays_clear", 32'(uf_a), 32'd0);

    // Single-bit word to show bit order on both instances.
    step(1'b1, 1'b1, 1'b1, {10'h000, 10'h000, 10'b1000000000});
    for (int n = 0; n < 12; n++) step(1'b1, 1'b0, 1'b1, '0);

    // Randomised traffic: gaps, enable drops, occasional clears.
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 9) != 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 15) == 0), rand_word());
    end

    // Freeze mid-word for 7 cycles.
    step(1'b1, 1'b1, 1'b0, rand_word());
    for (int n = 0; n < 12 && !(m_idx == 2 && m_cur != {LANES{IDLE}}); n++) step(1'b1, 1'b1, 1'b0, rand_word());
    for (int n = 0; n < 7; n++) step(1'b0, 1'b0, 1'b0, '0);
    for (int n = 0; n < 12; n++) step(1'b1, 1'b0, 1'b0, '0);

    // Reset at phase 2 with the hold register full.
    reached = 1'b0;
    for (int n = 0; n < 20 && !reached; n++) begin
      step(1'b1, 1'b1, 1'b0, rand_word());
      reached = (m_phase == 2) && (exp_q.size() == 1);
    end
    check("reached_phase2_hold_full", 32'(reached), 32'd1);
    do_reset(1'b1);
    for (int n = 0; n < 12; n++) step(1'b1, 1'b0, 1'b0, '0);

    @(negedge clk);
    check_outputs();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
